// File: rtl/one_counter_ctrl_if.sv
// Control/status bundle between the one-counter controller (master) and the
// one-counter datapath (slave): register-file, ALU and output-register controls.
interface one_counter_ctrl_if;
    logic        Start;
    logic [15:0] Datapath;
    logic        IE;
    logic [3:0]  WAA;
    logic [3:0]  WAB;
    logic [3:0]  RAA;
    logic [3:0]  RAB;
    logic        WEA;
    logic        WEB;
    logic        REA;
    logic        REB;
    logic [3:0]  S_ALU1;
    logic [3:0]  S_ALU2;
    logic        OE;
    logic        Busy;
    logic        Done;
    logic        Err;

    modport master (
        input  Start, Datapath,
        output IE, WAA, WAB, RAA, RAB, WEA, WEB, REA, REB,
        output S_ALU1, S_ALU2, OE, Busy, Done, Err
    );

    modport slave (
        output Start, Datapath,
        input  IE, WAA, WAB, RAA, RAB, WEA, WEB, REA, REB,
        input  S_ALU1, S_ALU2, OE, Busy, Done, Err
    );
endinterface

// File: rtl/one_counter_ctrl.sv
// Control FSM for the one-counter datapath: loads a word, shifts it right while
// counting set LSBs, latches the count into the output register and pulses Done.
module one_counter_ctrl #(
    parameter logic [3:0]  ADDR_CNT = 4'd0,
    parameter logic [3:0]  ADDR_DAT = 4'd1,
    parameter logic [3:0]  ALU_PASS = 4'd0,
    parameter logic [3:0]  ALU_INC  = 4'd1,
    parameter logic [3:0]  ALU_ZERO = 4'd2,
    parameter logic [3:0]  ALU_SHR  = 4'd3,
    parameter int unsigned MAX_ITER = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    one_counter_ctrl_if.master    bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [4:0] ITER_CAP = 5'(MAX_ITER);

    logic [2:0] state_q, state_d;
    logic [4:0] iter_q,  iter_d;
    logic       err_q,   err_d;

    logic       ie;
    logic [3:0] waa, wab, raa, rab;
    logic       wea, web, rea, reb;
    logic [3:0] s_alu1, s_alu2;
    logic       oe, done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            iter_q  <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from state (and Datapath in RUN), so an async reset
    // forces every control back to its idle value without waiting for a clock.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        err_d   = err_q;
        ie      = 1'b0;
        waa     = 4'd0;
        wab     = 4'd0;
        raa     = 4'd0;
        rab     = 4'd0;
        wea     = 1'b0;
        web     = 1'b0;
        rea     = 1'b0;
        reb     = 1'b0;
        s_alu1  = ALU_PASS;
        s_alu2  = ALU_PASS;
        oe      = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) state_d = S_LOAD;
            end
            S_LOAD: begin
                ie      = 1'b1;
                web     = 1'b1;
                wab     = ADDR_DAT;
                rea     = 1'b1;
                raa     = ADDR_CNT;
                s_alu1  = ALU_ZERO;
                wea     = 1'b1;
                waa     = ADDR_CNT;
                iter_d  = 5'd0;
                err_d   = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                reb = 1'b1;
                rab = ADDR_DAT;
                if (bus.Datapath == 16'd0) begin
                    state_d = S_OUT;
                end else if (iter_q == ITER_CAP) begin
                    // Word refused to drain: the datapath is not shifting.
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    s_alu2 = ALU_SHR;
                    web    = 1'b1;
                    wab    = ADDR_DAT;
                    if (bus.Datapath[0]) begin
                        rea    = 1'b1;
                        raa    = ADDR_CNT;
                        s_alu1 = ALU_INC;
                        wea    = 1'b1;
                        waa    = ADDR_CNT;
                    end
                    iter_d = iter_q + 5'd1;
                end
            end
            S_OUT: begin
                rea     = 1'b1;
                raa     = ADDR_CNT;
                s_alu1  = ALU_PASS;
                oe      = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.IE     = ie;
    assign bus.WAA    = waa;
    assign bus.WAB    = wab;
    assign bus.RAA    = raa;
    assign bus.RAB    = rab;
    assign bus.WEA    = wea;
    assign bus.WEB    = web;
    assign bus.REA    = rea;
    assign bus.REB    = reb;
    assign bus.S_ALU1 = s_alu1;
    assign bus.S_ALU2 = s_alu2;
    assign bus.OE     = oe;
    assign bus.Busy   = (state_q != S_IDLE);
    assign bus.Done   = done;
    assign bus.Err    = err_q;

endmodule

// File: doc/one_counter_ctrl.md
Name: one_counter_ctrl

Overview:
- Control FSM directly upstream of the one-counter datapath (register file, ALU1/ALU4, input mux, output register); drives every datapath control input.
- On Start, loads a 16-bit word into the datapath.
- Shifts the word right one bit per cycle, incrementing a count register whenever the LSB is 1, stopping once the word reaches zero.
- Latches the final count into the datapath output register and pulses Done.

Parameters:
ADDR_CNT, 4'd0, register-file address holding the ones count (A side)
ADDR_DAT, 4'd1, register-file address holding the working word (B side)
ALU_PASS, 4'd0, ALU select code: out = a
ALU_INC, 4'd1, ALU select code: out = a + 1
ALU_ZERO, 4'd2, ALU select code: out = 0
ALU_SHR, 4'd3, ALU select code: out = a >> 1 (logical)
MAX_ITER, 16, shift iterations allowed before the watchdog fires

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
Start  in  1  begin a count; sampled only in IDLE
Datapath  in  16  RDB read-back of the working word (combinational from RF)
IE  out  1  input-mux select: 1 = DataIn, 0 = ALU4 result
WAA, WAB, RAA, RAB  out  4 each  register-file addresses
WEA, WEB, REA, REB  out  1 each  register-file enables
S_ALU1, S_ALU2  out  4 each  ALU select codes
OE  out  1  load enable of the datapath output register
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse when the output register holds a valid count
Err  out  1  sticky watchdog flag; cleared by RST or the next accepted Start

Behaviour:
- Reset (async, any state, including mid-operation):
  - State goes to IDLE.
  - All enables, IE, OE, Busy and Done go to 0.
  - All addresses go to 0, S_ALU1/S_ALU2 go to ALU_PASS, Err goes to 0, iteration counter goes to 0.
- Default value of every output in any state, unless that state drives it: same as the reset value.
- States and transitions:
  - IDLE: Start=1 -> LOAD; otherwise stay.
  - LOAD (1 cycle):
    - IE=1, WEB=1, WAB=ADDR_DAT (captures DataIn).
    - REA=1, RAA=ADDR_CNT, S_ALU1=ALU_ZERO, WEA=1, WAA=ADDR_CNT (clears the count).
    - Clears the iteration counter and Err. Next state RUN.
  - RUN (Mealy on Datapath; REB=1, RAB=ADDR_DAT every cycle):
    - If Datapath==0: no writes; next state OUT.
    - Else if iteration counter==MAX_ITER: set Err; next state OUT.
    - Otherwise:
      - IE=0, S_ALU2=ALU_SHR, WEB=1, WAB=ADDR_DAT.
      - If Datapath[0]=1, also REA=1, RAA=ADDR_CNT, S_ALU1=ALU_INC, WEA=1, WAA=ADDR_CNT in the same cycle.
      - Iteration counter +1; stay in RUN.
  - OUT (1 cycle): REA=1, RAA=ADDR_CNT, S_ALU1=ALU_PASS, OE=1. Next state DONE.
  - DONE (1 cycle): Done=1. Next state IDLE.
- Latency from the Start cycle to the Done pulse:
  - Start accepted at edge 0; LOAD, then RUN for k+1 cycles (k = index of the highest set bit + 1; k=0 for input 0), then OUT, then DONE.
  - Done is high k+4 cycles after the Start-sampling edge. Maximum is 20.
- Output register holds the count (0..16) from the edge ending OUT until the next OUT.
- Start while Busy=1 is ignored. Start held high re-triggers from IDLE in the cycle after DONE.
- Iteration counter is 5 bits wide; it cannot overflow because the watchdog caps it at MAX_ITER.
- Err can only fire if the datapath misbehaves (word not shifting). Err stays set until RST or the next LOAD.

Test Plan:
- Reset: assert RST mid-RUN with DataIn=16'hFFFF -> all outputs take reset values immediately (asynchronously); Start next cycle -> normal run, Out=16.
- Zero word: DataIn=16'h0000, Start pulse -> RUN lasts 1 cycle, Out=0, Done 4 cycles after Start.
- Full word: DataIn=16'hFFFF -> 16 shift cycles each asserting WEA with S_ALU1=ALU_INC, Out=16, Done at cycle 20, Err=0.
- Sparse word: DataIn=16'h8001 -> Out=2, 16 shift cycles, WEA asserted only on the first and last shift cycles.
- Handshake: Start pulsed again during RUN of DataIn=16'h00F0 -> ignored, Out=4. Start held high through DONE -> second run begins the cycle after DONE.
- Watchdog: datapath model with WEB writes disabled and Datapath stuck at 16'h0001 -> Err=1 after 16 iterations, OE=1 in OUT, Done pulses; the next Start clears Err.
